// File: rtl/pll_reset_sequencer.sv
// PLL lock synchroniser, lock filter, reset hold sequencer and clock enables.
// Optional lock filtering: define PLL_RESET_LOCK_FILTER_EN.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int HOLD_CYCLES   = 1024
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       sys_reset_n,
  output logic       ce_21m,
  output logic       ce_10m,
  output logic       ready,
  output logic [7:0] lock_lost_count
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
    $error("FILTER_CYCLES out of range");
  end
  if (HOLD_CYCLES < 8 || HOLD_CYCLES > 65536 || HOLD_CYCLES % 8 != 0)
  begin : g_bad_hold
    $error("HOLD_CYCLES out of range");
  end

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

`ifdef PLL_RESET_LOCK_FILTER_EN
  localparam logic [15:0] FILTER_LAST = 16'(FILTER_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;
`endif

  state_t                   state;
  state_t                   state_n;
  logic [SYNC_STAGES-1:0]   sync;
  logic                     locked_s;
  logic [15:0]              cnt;
  logic [15:0]              cnt_n;
  logic [2:0]               phase;
  logic [2:0]               phase_n;
  logic                     active;
  logic                     active_n;
  logic [7:0]               lost_n;

  assign locked_s = sync[SYNC_STAGES-1];
  assign active   = (state == HOLD) || (state == RUN);
  assign ready    = (state == RUN);

  always_comb begin
    state_n = state;
    case (state)
      WAIT_LOCK: begin
`ifdef PLL_RESET_LOCK_FILTER_EN
        if (locked_s) state_n = FILTER;
`else
        if (locked_s) state_n = HOLD;
`endif
      end
`ifdef PLL_RESET_LOCK_FILTER_EN
      FILTER: begin
        if (!locked_s)                state_n = WAIT_LOCK;
        else if (cnt == FILTER_LAST)  state_n = HOLD;
      end
`endif
      HOLD: begin
        if (!locked_s)              state_n = WAIT_LOCK;
        else if (cnt == HOLD_LAST)  state_n = RUN;
      end
      RUN: begin
        if (!locked_s) state_n = WAIT_LOCK;
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  // Phase restarts on HOLD entry; HOLD length is a multiple of 8,
  // so RUN always begins on phase 0.
  always_comb begin
    active_n = (state_n == HOLD) || (state_n == RUN);
    phase_n  = 3'd0;
    if (active_n && active) phase_n = phase + 3'd1;
    cnt_n = (state_n != state) ? 16'd0 : cnt + 16'd1;
    lost_n = lock_lost_count;
    if (state == RUN && state_n == WAIT_LOCK && lock_lost_count != 8'hff)
      lost_n = lock_lost_count + 8'd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync            <= '0;
      state           <= WAIT_LOCK;
      cnt             <= '0;
      phase           <= '0;
      sys_reset_n     <= 1'b0;
      ce_21m          <= 1'b0;
      ce_10m          <= 1'b0;
      lock_lost_count <= '0;
    end else begin
      sync            <= {sync[SYNC_STAGES-2:0], pll_locked};
      state           <= state_n;
      cnt             <= cnt_n;
      phase           <= phase_n;
      sys_reset_n     <= (state_n == RUN);
      ce_21m          <= active_n && (phase_n[1:0] == 2'd3);
      ce_10m          <= active_n && (phase_n == 3'd7);
      lock_lost_count <= lost_n;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: lock-streak reference model, directed
// latency/enable scenarios and randomized lock toggling on two instances.
module tb_pll_reset_sequencer;

  localparam int S0 = 2;
  localparam int H0 = 1024;
  localparam int S1 = 3;
  localparam int H1 = 8;
`ifdef PLL_RESET_LOCK_FILTER_EN
  localparam int F0 = 16;
  localparam int F1 = 3;
`else
  localparam int F0 = 0;
  localparam int F1 = 0;
`endif
  localparam int LAT0 = S0 + 1 + F0 + H0;
  localparam int LAT1 = S1 + 1 + F1 + H1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_locked_f = 1'b0;
  logic       sys_reset_n, ce_21m, ce_10m, ready;
  logic [7:0] lock_lost_count;
  logic       sys_reset_n_f, ce_21m_f, ce_10m_f, ready_f;
  logic [7:0] lock_lost_count_f;

  int n_checks = 0;
  int n_fail = 0;

  int         streak[2];
  int         lost[2];
  logic [3:0] hist[2];

  always #5 clk = ~clk;

  pll_reset_sequencer dut (
    .clk_sys(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .sys_reset_n(sys_reset_n), .ce_21m(ce_21m), .ce_10m(ce_10m),
    .ready(ready), .lock_lost_count(lock_lost_count)
  );

  pll_reset_sequencer #(
    .SYNC_STAGES(S1), .FILTER_CYCLES(3), .HOLD_CYCLES(H1)
  ) dut_f (
    .clk_sys(clk), .reset_n(reset_n), .pll_locked(pll_locked_f),
    .sys_reset_n(sys_reset_n_f), .ce_21m(ce_21m_f), .ce_10m(ce_10m_f),
    .ready(ready_f), .lock_lost_count(lock_lost_count_f)
  );

  function automatic int ss(int i); return i == 0 ? S0 : S1; endfunction
  function automatic int ff(int i); return i == 0 ? F0 : F1; endfunction
  function automatic int hh(int i); return i == 0 ? H0 : H1; endfunction

  function automatic logic g_srn(int i);
    return i == 0 ? sys_reset_n : sys_reset_n_f;
  endfunction
  function automatic logic g_c21(int i);
    return i == 0 ? ce_21m : ce_21m_f;
  endfunction
  function automatic logic g_c10(int i);
    return i == 0 ? ce_10m : ce_10m_f;
  endfunction
  function automatic logic g_rdy(int i);
    return i == 0 ? ready : ready_f;
  endfunction
  function automatic int g_lost(int i);
    return i == 0 ? int'(lock_lost_count) : int'(lock_lost_count_f);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hist[i] = '0;
      streak[i] = 0;
      lost[i] = 0;
    end
  endtask

  // The core is in RUN once locked_s has been high F+H+1 cycles running;
  // HOLD/RUN phase counts from the cycle the streak passes F.
  task automatic model_edge();
    logic pl, ls;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      pl = (i == 0) ? pll_locked : pll_locked_f;
      ls = hist[i][ss(i)-1];
      hist[i] = {hist[i][2:0], pl};
      if (ls) streak[i]++;
      else begin
        if (streak[i] >= ff(i) + hh(i) + 1 && lost[i] < 255) lost[i]++;
        streak[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    int st, ph;
    logic run, act;
    for (int i = 0; i < 2; i++) begin
      st  = streak[i];
      run = st >= ff(i) + hh(i) + 1;
      act = st >= ff(i) + 1;
      ph  = act ? (st - ff(i) - 1) % 8 : 0;
      check($sformatf("sys_reset_n[%0d]", i), int'(g_srn(i)), int'(run));
      check($sformatf("ready[%0d]", i), int'(g_rdy(i)), int'(run));
      check($sformatf("ce_21m[%0d]", i), int'(g_c21(i)),
            int'(act && (ph % 4 == 3)));
      check($sformatf("ce_10m[%0d]", i), int'(g_c10(i)),
            int'(act && ph == 7));
      check($sformatf("lost[%0d]", i), g_lost(i), lost[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_level(input int i, input logic lvl, output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (g_srn(i) !== lvl && edges < 3000);
  endtask

  task automatic wait_ce(input int which, output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (((which == 0) ? ce_21m : ce_10m) !== 1'b1 && edges < 50);
  endtask

  initial begin
    int e;
    model_reset();
    #1;
    check_all();
    steps(2);
    check("reset_srn", int'(sys_reset_n), 0);
    reset_n = 1'b1;

    // lock, 1-cycle glitch at filter count 10, then full latency again
    pll_locked = 1'b1;
    steps(S0 + 1 + 10);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_level(0, 1'b1, e);
    check("lat_after_glitch", e, LAT0);
    check("glitch_lost", int'(lock_lost_count), 0);
    check("ready_at_rise", int'(ready), 1);
    check("ce21_at_rise", int'(ce_21m), 0);

    wait_ce(0, e);
    check("first_ce21", e, 3);
    wait_ce(0, e);
    check("ce21_period", e, 4);
    wait_ce(1, e);
    check("ce10_with_ce21", int'(ce_21m), 1);
    wait_ce(1, e);
    check("ce10_period", e, 8);

    // loss in RUN, then clean relock
    pll_locked = 1'b0;
    wait_level(0, 1'b0, e);
    check("fall_lat", e, S0 + 1);
    check("lost_one", int'(lock_lost_count), 1);
    steps(3);
    pll_locked = 1'b1;
    wait_level(0, 1'b1, e);
    check("lat_clean", e, LAT0);

    // reset pulse mid-HOLD restarts the whole sequence
    pll_locked = 1'b0;
    wait_level(0, 1'b0, e);
    pll_locked = 1'b1;
    steps(500);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_srn", int'(sys_reset_n), 0);
    check("async_lost", int'(lock_lost_count), 0);
    check_all();
    steps(2);
    reset_n = 1'b1;
    wait_level(0, 1'b1, e);
    check("lat_after_reset", e, LAT0);

    // 300 lock losses on the short-hold instance
    for (int n = 0; n < 300; n++) begin
      pll_locked_f = 1'b1;
      wait_level(1, 1'b1, e);
      check("lat_f", e, LAT1);
      steps($urandom_range(0, 6));
      pll_locked_f = 1'b0;
      wait_level(1, 1'b0, e);
      check("fall_lat_f", e, S1 + 1);
      steps($urandom_range(0, 3));
    end
    check("lost_sat", int'(lock_lost_count_f), 255);

    // random lock toggling on both instances
    for (int n = 0; n < 150; n++) begin
      pll_locked_f = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pll_locked = ~pll_locked;
      steps($urandom_range(1, 25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the locked synchroniser (2..4).
REQ-002 Parameter FILTER_CYCLES, default 16: cycles locked must stay high before hold starts (1..255).
REQ-003 Parameter HOLD_CYCLES, default 1024: cycles reset is held after filtering; must be a multiple of 8, range 8..65536.
REQ-004 clk_sys  in  1: system clock, 85.909080 MHz PLL output 0; all logic on its rising edge.
REQ-005 reset_n  in  1: asynchronous, active-low reset.
REQ-006 pll_locked  in  1: PLL lock indication, asynchronous to clk_sys.
REQ-007 sys_reset_n  out  1: registered active-low reset for the core.
REQ-008 ce_21m  out  1: clock enable, 1 cycle in 4 (21.477270 MHz rate).
REQ-009 ce_10m  out  1: clock enable, 1 cycle in 8 (10.738635 MHz rate).
REQ-010 ready  out  1: high exactly when the state is RUN.
REQ-011 lock_lost_count  out  8: saturating count of lock losses seen in RUN.

Function
REQ-012 pll_locked SHALL pass through SYNC_STAGES flops, all reset to 0, giving locked_s.
REQ-013 State machine states SHALL be WAIT_LOCK, FILTER, HOLD and RUN.
- WAIT_LOCK: locked_s=1 -> FILTER (HOLD when filtering is compiled out).
- FILTER: locked_s=0 -> WAIT_LOCK; after FILTER_CYCLES cycles -> HOLD.
- HOLD: locked_s=0 -> WAIT_LOCK; after HOLD_CYCLES cycles -> RUN.
- RUN: locked_s=0 -> WAIT_LOCK.
REQ-014 The 16-bit cycle counter SHALL clear on every state change and increment otherwise.
REQ-015 The 3-bit phase counter SHALL clear on entry to HOLD, increment every cycle in HOLD and RUN, wrap 7->0, and hold at 0 in WAIT_LOCK and FILTER.
REQ-016 ce_21m SHALL be registered high when phase[1:0]==3, in HOLD and RUN only.
REQ-017 ce_10m SHALL be registered high when phase==7, in HOLD and RUN only; every ce_10m pulse coincides with a ce_21m pulse.
REQ-018 sys_reset_n SHALL be registered from (next state == RUN).
- It rises on the first RUN cycle with phase==0.
- It falls on the cycle after locked_s drops.
REQ-019 Rise latency SHALL be SYNC_STAGES+1+FILTER_CYCLES+HOLD_CYCLES edges from the first clk_sys edge that samples pll_locked high.
REQ-020 On a RUN->WAIT_LOCK transition, lock_lost_count SHALL increment, saturating at 255; losses in FILTER or HOLD SHALL NOT count.
REQ-021 A lock drop in the same cycle the FILTER or HOLD terminal count is reached SHALL take priority: next state is WAIT_LOCK.
REQ-022 ce outputs SHALL be 0 in the cycle after any entry to WAIT_LOCK.

Reset
REQ-023 While reset_n=0 the block SHALL immediately force the following, independent of clk_sys:
- state=WAIT_LOCK;
- all counters and synchroniser flops to 0;
- sys_reset_n=0, ce_21m=0, ce_10m=0, ready=0, lock_lost_count=0.
REQ-024 Reset deassertion SHALL take effect on the first clk_sys edge after reset_n rises; asserting reset mid-HOLD or mid-RUN SHALL restart the full sequence.

Configuration
REQ-025 Macro PLL_RESET_LOCK_FILTER_EN SHALL control filtering.
- Defined: the FILTER state exists as specified.
- Undefined: FILTER is removed, WAIT_LOCK goes directly to HOLD, FILTER_CYCLES is ignored, and rise latency is SYNC_STAGES+1+HOLD_CYCLES.

Verification
REQ-026 The bench SHALL cover the following directed scenarios (default parameters):
- Filter defined, pll_locked rises and stays high: sys_reset_n rises after exactly 1043 edges; ready rises the same cycle; phase=0.
- Filter undefined, same stimulus: sys_reset_n rises after exactly 1027 edges.
- In RUN: ce_21m period is 4 cycles and ce_10m period is 8 cycles; ce_10m is always coincident with ce_21m; first ce_21m occurs 3 cycles after RUN entry.
- pll_locked pulses low for 1 cycle in FILTER at count 10: return to WAIT_LOCK, lock_lost_count stays 0, full latency restarts.
- 300 lock losses in RUN: sys_reset_n falls SYNC_STAGES+1 edges after each drop; lock_lost_count ends at 255.
- reset_n pulsed low mid-HOLD: all outputs go to 0 asynchronously; after release with pll_locked high, sys_reset_n rises after 1043 edges.
